// File: rtl/frame_loader.sv
// frame_loader: packs a valid/ready byte stream MSB-first into either the
// 192-bit encoder frame or the 384-bit decoder frame, then holds the finished
// frame stable with o_frame_valid high until downstream releases it.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module frame_loader #(
    parameter int BYTE_W       = 8,
    parameter int ENC_BYTES    = 24,
    parameter int DEC_BYTES_R2 = 32,
    parameter int DEC_BYTES_R3 = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_mode,
    input  logic                           i_code_rate,
    input  logic [BYTE_W-1:0]              i_byte,
    input  logic                           i_byte_valid,
    output logic                           o_byte_ready,
    input  logic                           i_release,
    output logic [ENC_BYTES*BYTE_W-1:0]    o_encoder_data_frame,
    output logic [DEC_BYTES_R3*BYTE_W-1:0] o_decoder_data_frame,
    output logic                           o_frame_valid,
    output logic                           o_busy
);

    localparam int ENC_W    = ENC_BYTES * BYTE_W;
    localparam int DEC_W    = DEC_BYTES_R3 * BYTE_W;
    localparam int DEC_R2_W = DEC_BYTES_R2 * BYTE_W;
    localparam int ENC_IW   = $clog2(ENC_W);
    localparam int DEC_IW   = $clog2(DEC_W);
    localparam int K_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                mode_r;
    logic                rate_r;
    logic [K_W-1:0]      k_r;
    logic [K_W-1:0]      last_s;
    logic [ENC_W-1:0]    enc_frame_r;
    logic [DEC_W-1:0]    dec_frame_r;
    logic                byte_ready_s;
    logic                frame_valid_s;
    logic                busy_s;
    logic                start_s;
    logic                xfer_s;
    logic                last_xfer_s;
    logic [DEC_IW-1:0]   k_off_s;
    logic [ENC_IW-1:0]   enc_base_s;
    logic [DEC_IW-1:0]   dec_base_s;

    // Index of the final byte of a frame for the latched mode and code rate.
    function automatic logic [K_W-1:0] target_last(input logic mode, input logic rate);
        logic [K_W-1:0] last;
        if (!mode) begin
            last = K_W'(ENC_BYTES - 1);
        end else if (rate == `CODE_RATE_3) begin
            last = K_W'(DEC_BYTES_R3 - 1);
        end else begin
            last = K_W'(DEC_BYTES_R2 - 1);
        end
        return last;
    endfunction

    // Handshake qualifiers and the frame-length target for the current load.
    always_comb begin
        start_s     = (state_r == ST_IDLE) && i_start;
        xfer_s      = byte_ready_s && i_byte_valid;
        last_s      = target_last(mode_r, rate_r);
        last_xfer_s = xfer_s && (k_r == last_s);
    end

    // Bit position of byte k: earliest byte lands in the top byte lane of the used region.
    always_comb begin
        k_off_s    = DEC_IW'(k_r) * DEC_IW'(BYTE_W);
        enc_base_s = ENC_IW'(ENC_W - 1) - k_off_s[ENC_IW-1:0];
        if (rate_r == `CODE_RATE_3) begin
            dec_base_s = DEC_IW'(DEC_W - 1) - k_off_s;
        end else begin
            dec_base_s = DEC_IW'(DEC_R2_W - 1) - k_off_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; release in FULL takes priority and any start there is dropped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_xfer_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (i_release) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode purely from the state register, so ready has no input path.
    always_comb begin
        byte_ready_s  = 1'b0;
        frame_valid_s = 1'b0;
        busy_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                byte_ready_s  = 1'b0;
                frame_valid_s = 1'b0;
                busy_s        = 1'b0;
            end
            ST_LOAD: begin
                byte_ready_s  = 1'b1;
                frame_valid_s = 1'b0;
                busy_s        = 1'b1;
            end
            ST_FULL: begin
                byte_ready_s  = 1'b0;
                frame_valid_s = 1'b1;
                busy_s        = 1'b1;
            end
            default: begin
                byte_ready_s  = 1'b0;
                frame_valid_s = 1'b0;
                busy_s        = 1'b0;
            end
        endcase
    end

    // Mode/rate latch and byte counter; counter wraps to zero on the final byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_r <= 1'b0;
            rate_r <= `CODE_RATE_2;
            k_r    <= {K_W{1'b0}};
        end else if (start_s) begin
            mode_r <= i_mode;
            rate_r <= i_code_rate;
            k_r    <= {K_W{1'b0}};
        end else if (xfer_s) begin
            if (last_xfer_s) begin
                k_r <= {K_W{1'b0}};
            end else begin
                k_r <= k_r + 6'd1;
            end
        end
    end

    // Frame storage: cleared on start, one byte lane written per transfer, otherwise frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enc_frame_r <= {ENC_W{1'b0}};
            dec_frame_r <= {DEC_W{1'b0}};
        end else if (start_s) begin
            enc_frame_r <= {ENC_W{1'b0}};
            dec_frame_r <= {DEC_W{1'b0}};
        end else if (xfer_s) begin
            if (!mode_r) begin
                enc_frame_r[enc_base_s -: BYTE_W] <= i_byte;
            end else begin
                dec_frame_r[dec_base_s -: BYTE_W] <= i_byte;
            end
        end
    end

    // Drive ports.
    always_comb begin
        o_byte_ready         = byte_ready_s;
        o_frame_valid        = frame_valid_s;
        o_busy               = busy_s;
        o_encoder_data_frame = enc_frame_r;
        o_decoder_data_frame = dec_frame_r;
    end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: stimulus pushes the expected frame and
// transfer count; a negedge monitor pops and compares when o_frame_valid rises.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic         i_mode;
    logic         i_code_rate;
    logic [7:0]   i_byte;
    logic         i_byte_valid;
    logic         o_byte_ready;
    logic         i_release;
    logic [191:0] o_encoder_data_frame;
    logic [383:0] o_decoder_data_frame;
    logic         o_frame_valid;
    logic         o_busy;

    typedef struct {
        logic [191:0] enc;
        logic [383:0] dec;
        int           cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] data_a[48];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         hs_cnt  = 0;
    logic       fv_prev = 1'b0;

    always #5 clk = ~clk;

    frame_loader dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (i_start),
        .i_mode               (i_mode),
        .i_code_rate          (i_code_rate),
        .i_byte               (i_byte),
        .i_byte_valid         (i_byte_valid),
        .o_byte_ready         (o_byte_ready),
        .i_release            (i_release),
        .o_encoder_data_frame (o_encoder_data_frame),
        .o_decoder_data_frame (o_decoder_data_frame),
        .o_frame_valid        (o_frame_valid),
        .o_busy               (o_busy)
    );

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count handshakes, compare against scoreboard on frame_valid rise.
    always @(negedge clk) begin
        if (!rst) begin
            hs_cnt  = 0;
            fv_prev = 1'b0;
        end else begin
            if (o_byte_ready && i_byte_valid) hs_cnt++;
            if (o_frame_valid && !fv_prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_frame: got frame_valid with no expected frame queued");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_enc_frame", o_encoder_data_frame, mon_e.enc);
                    chk("sb_dec_frame", o_decoder_data_frame, mon_e.dec);
                    chk("sb_transfer_count", hs_cnt, mon_e.cnt);
                    chk("sb_ready_low_when_full", o_byte_ready, 1'b0);
                end
                hs_cnt = 0;
            end
            fv_prev = o_frame_valid;
        end
    end

    // Load one frame; abort_after >= 0 stops after that many bytes (no scoreboard entry).
    task automatic send_frame(input logic mode, input logic rate, input int n,
                              input bit gaps, input int abort_after);
        exp_t e;
        int   sent;
        int   c;
        e.enc = '0;
        e.dec = '0;
        e.cnt = n;
        for (int k = 0; k < n; k++) begin
            if (!mode) e.enc = {e.enc[183:0], data_a[k]};
            else       e.dec = {e.dec[375:0], data_a[k]};
        end
        if (abort_after < 0) exp_q.push_back(e);
        @(posedge clk); #1;
        i_start = 1'b1; i_mode = mode; i_code_rate = rate;
        @(posedge clk); #1;
        i_start = 1'b0; i_mode = ~mode; i_code_rate = ~rate;
        chk("start_clears_enc", o_encoder_data_frame, 384'd0);
        chk("start_clears_dec", o_decoder_data_frame, 384'd0);
        chk("busy_in_load", o_busy, 1'b1);
        chk("ready_in_load", o_byte_ready, 1'b1);
        sent = 0;
        c    = 0;
        while (sent < n && c < 200) begin
            if (abort_after >= 0 && sent == abort_after) break;
            if (gaps && (c % 3 == 2)) begin
                i_byte_valid = 1'b0;
                i_release    = 1'b1;
            end else begin
                i_byte_valid = 1'b1;
                i_byte       = data_a[sent];
                i_release    = 1'b0;
            end
            @(posedge clk); #1;
            if (i_byte_valid) sent++;
            c++;
        end
        i_byte_valid = 1'b0;
        i_release    = 1'b0;
        i_byte       = 8'h00;
        if (abort_after < 0) begin
            chk("all_bytes_sent", sent, n);
            chk("valid_cycle_after_last", o_frame_valid, 1'b1);
            chk("ready_drops_at_full", o_byte_ready, 1'b0);
        end
    endtask

    task automatic release_frame(input bit with_start);
        i_release = 1'b1;
        i_start   = with_start;
        @(posedge clk); #1;
        i_release = 1'b0;
        i_start   = 1'b0;
        chk("valid_low_after_release", o_frame_valid, 1'b0);
        chk("idle_after_release", o_busy, 1'b0);
        chk("ready_low_in_idle", o_byte_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_code_rate = `CODE_RATE_2;
        i_byte = 8'h00; i_byte_valid = 1'b0; i_release = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc", o_encoder_data_frame, 384'd0);
        chk("rst_dec", o_decoder_data_frame, 384'd0);
        chk("rst_valid", o_frame_valid, 1'b0);
        chk("rst_ready", o_byte_ready, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        rst = 1'b1;

        // Encoder frame 0x00..0x17, no gaps
        for (int k = 0; k < 24; k++) data_a[k] = 8'(k);
        send_frame(1'b0, `CODE_RATE_2, 24, 1'b0, -1);
        chk("enc_byte0", o_encoder_data_frame[191:184], 8'h00);
        chk("enc_byte1", o_encoder_data_frame[183:176], 8'h01);
        chk("enc_byte23", o_encoder_data_frame[7:0], 8'h17);
        chk("enc_dec_zero", o_decoder_data_frame, 384'd0);

        // Hold: bytes and start ignored while FULL
        i_byte_valid = 1'b1; i_byte = 8'hFF; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        i_byte_valid = 1'b0;
        chk("hold_enc_frozen", o_encoder_data_frame,
            192'h000102030405060708090a0b0c0d0e0f1011121314151617);
        chk("hold_ready_low", o_byte_ready, 1'b0);
        chk("hold_valid_high", o_frame_valid, 1'b1);
        release_frame(1'b1);
        @(posedge clk); #1;
        chk("start_with_release_dropped", o_busy, 1'b0);
        chk("enc_retained_after_release", o_encoder_data_frame,
            192'h000102030405060708090a0b0c0d0e0f1011121314151617);

        // Decoder rate 1/2: 32 x 0xA5
        for (int k = 0; k < 32; k++) data_a[k] = 8'hA5;
        send_frame(1'b1, `CODE_RATE_2, 32, 1'b0, -1);
        chk("r2_low_pattern", o_decoder_data_frame[255:0], {32{8'hA5}});
        chk("r2_high_zero", o_decoder_data_frame[383:256], 128'd0);
        chk("r2_enc_zero", o_encoder_data_frame, 384'd0);
        release_frame(1'b0);

        // Decoder rate 1/3 with valid gaps every third cycle
        for (int k = 0; k < 48; k++) data_a[k] = 8'(k + 1);
        send_frame(1'b1, `CODE_RATE_3, 48, 1'b1, -1);
        chk("r3_first", o_decoder_data_frame[383:376], 8'h01);
        chk("r3_last", o_decoder_data_frame[7:0], 8'h30);
        chk("r3_mid", o_decoder_data_frame[199:192], 8'h18);
        release_frame(1'b0);

        // Back-to-back encoder frame with a different pattern
        for (int k = 0; k < 24; k++) data_a[k] = 8'h80 ^ 8'(k);
        send_frame(1'b0, `CODE_RATE_3, 24, 1'b0, -1);
        chk("b2b_first", o_encoder_data_frame[191:184], 8'h80);
        chk("b2b_last", o_encoder_data_frame[7:0], 8'h97);
        release_frame(1'b0);

        // Reset in the middle of a load
        for (int k = 0; k < 24; k++) data_a[k] = 8'h40 + 8'(k);
        send_frame(1'b0, `CODE_RATE_2, 24, 1'b0, 10);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_enc", o_encoder_data_frame, 384'd0);
        chk("midrst_valid", o_frame_valid, 1'b0);
        chk("midrst_ready", o_byte_ready, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        rst = 1'b1;
        send_frame(1'b0, `CODE_RATE_2, 24, 1'b0, -1);
        chk("after_rst_first", o_encoder_data_frame[191:184], 8'h40);
        chk("after_rst_last", o_encoder_data_frame[7:0], 8'h57);
        release_frame(1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream feeder for the frame slicer stage. Accepts a byte stream over a valid/ready handshake and packs it MSB-first into either the 192-bit encoder frame or the 384-bit decoder frame.
- Holds the completed frame stable and flags it valid until the downstream slicer/control releases it.
- Sits between the host byte interface and the slicer. Its frame outputs wire directly to the slicer's frame inputs.

Parameters:
- BYTE_W, 8, width of one input transfer.
- ENC_BYTES, 24, bytes per encoder frame (192 bits).
- DEC_BYTES_R2, 32, bytes per decoder frame at code rate 1/2 (256 bits used).
- DEC_BYTES_R3, 48, bytes per decoder frame at code rate 1/3 (384 bits used).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- i_start  input  1  one-cycle request to begin loading a frame; honoured only in IDLE.
- i_mode  input  1  0 = encoder frame, 1 = decoder frame; sampled with i_start.
- i_code_rate  input  1  `CODE_RATE_2` / `CODE_RATE_3` encoding from param_def.sv; sampled with i_start; used only when i_mode = 1.
- i_byte  input  BYTE_W  data byte; bit 7 is the earliest bit in stream order.
- i_byte_valid  input  1  byte present.
- o_byte_ready  output  1  loader accepts a byte this cycle.
- i_release  input  1  downstream has finished with the frame.
- o_encoder_data_frame  output  192  packed encoder frame.
- o_decoder_data_frame  output  384  packed decoder frame.
- o_frame_valid  output  1  frame complete and stable.
- o_busy  output  1  high in LOAD or FULL.

Behaviour:
- Reset (rst = 0 at posedge): state = IDLE, byte counter = 0, both frames = 0, o_frame_valid = 0, o_byte_ready = 0, o_busy = 0. Reset mid-LOAD or mid-FULL discards the partial or held frame.
- Latched mode and rate are held in registers. The target count is:
  - ENC_BYTES when mode = 0.
  - DEC_BYTES_R2 when mode = 1 and rate = `CODE_RATE_2`.
  - DEC_BYTES_R3 when mode = 1 and rate = `CODE_RATE_3`.
- Byte counter k is 6 bits wide and counts 0 up to target-1.
- State IDLE:
  - o_byte_ready = 0.
  - On i_start: latch i_mode and i_code_rate, clear both frame registers to 0, clear k, go to LOAD.
- State LOAD:
  - o_byte_ready = 1, decoded from the state register, no combinational path from inputs.
  - A transfer occurs when i_byte_valid and o_byte_ready are both high. i_byte_valid gaps stall with no effect.
  - Encoder placement: byte k is written to o_encoder_data_frame[191-8k -: 8].
  - Decoder rate 1/2: byte k is written to o_decoder_data_frame[255-8k -: 8]; bits [383:256] stay 0.
  - Decoder rate 1/3: byte k is written to o_decoder_data_frame[383-8k -: 8].
  - The frame not selected by mode stays 0.
  - On the transfer with k = target-1: go to FULL. o_frame_valid = 1 from the next cycle, and o_byte_ready drops in that same cycle, so no extra byte is accepted.
- State FULL:
  - o_byte_ready = 0, o_frame_valid = 1, frame registers frozen.
  - On i_release: go to IDLE; o_frame_valid = 0 the next cycle. Frame contents are retained until the next accepted i_start or reset.
- i_start in LOAD or FULL is ignored, including i_start and i_release in the same FULL cycle: release wins and the start is dropped. i_release outside FULL is ignored.
- Mode and rate inputs changing after i_start has no effect until the next accepted i_start.
- o_busy = (state != IDLE).
- Latency: a frame of N bytes with no gaps takes N cycles in LOAD, plus one cycle to o_frame_valid.

Test Plan:
- Encoder frame, no gaps: i_mode = 0, i_start, then bytes 0x00..0x17 -> o_frame_valid rises the cycle after the 24th handshake; [191:184] = 0x00, [183:176] = 0x01, [7:0] = 0x17; o_decoder_data_frame = 0.
- Decoder rate 1/2: i_mode = 1, `CODE_RATE_2`, 32 bytes of 0xA5 -> [255:0] is the repeated 0xA5 pattern, [383:256] = 0, o_frame_valid after byte 32, o_byte_ready low in that cycle.
- Decoder rate 1/3 with gaps: 48 bytes 0x01..0x30, with i_byte_valid low every third cycle -> [383:376] = 0x01, [7:0] = 0x30; exactly 48 transfers counted.
- Hold and release: in FULL, drive i_byte_valid high with 0xFF and pulse i_start -> frame unchanged, o_byte_ready = 0. Then pulse i_release together with i_start -> IDLE, o_frame_valid = 0 next cycle, start ignored.
- Back-to-back frames: after release, start an encoder frame -> both frames read 0 the cycle after i_start, then fill correctly.
- Reset mid-load: assert rst = 0 after 10 bytes -> all outputs 0 next cycle; a new full frame then loads correctly from k = 0.
